instr_controller: RTL

- Moore FSM that sequences the 16-bit register-file/ALU datapath, one instruction at a time.
- Takes opcode/op from the instruction decoder and a start strobe from the top level.
- Drives the decoder's one-hot register select and all datapath load, write and mux-select controls.
- Signals idle/ready back to the top level via w.

---
 rtl/instr_controller.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/instr_controller.sv
// Moore controller sequencing the register-file/ALU datapath one instruction at a time.
// Outputs are registered copies of the decode of the next state, so they always match the state register.
module instr_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       write,
  output logic [1:0] vsel,
  output logic       asel,
  output logic       bsel,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_WAIT   = 4'd0,
    S_DECODE = 4'd1,
    S_WIMM   = 4'd2,
    S_GETA   = 4'd3,
    S_GETB   = 4'd4,
    S_ALU    = 4'd5,
    S_CMP    = 4'd6,
    S_WREG   = 4'd7,
    S_ILL    = 4'd8
  } state_t;

  localparam logic [2:0] C_ADD  = 3'd0;
  localparam logic [2:0] C_CMP  = 3'd1;
  localparam logic [2:0] C_AND  = 3'd2;
  localparam logic [2:0] C_MVN  = 3'd3;
  localparam logic [2:0] C_MOVR = 3'd4;

  state_t     state_q, state_d;
  logic [2:0] cls_q, cls_d;
  logic       mov_q, mov_d;

  logic       w_q, w_d;
  logic [2:0] nsel_q, nsel_d;
  logic       loada_q, loada_d, loadb_q, loadb_d, loadc_q, loadc_d;
  logic       loads_q, loads_d, write_q, write_d;
  logic [1:0] vsel_q, vsel_d;
  logic       asel_q, asel_d, illegal_q, illegal_d;

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    mov_d   = mov_q;
    case (state_q)
      S_WAIT:   if (s) state_d = S_DECODE;
      // Instruction class is latched here; later states never look at opcode/op again.
      S_DECODE: begin
        mov_d = 1'b0;
        case ({opcode, op})
          5'b110_10: state_d = S_WIMM;
          5'b110_00: begin state_d = S_GETB; cls_d = C_MOVR; mov_d = 1'b1; end
          5'b101_00: begin state_d = S_GETA; cls_d = C_ADD; end
          5'b101_01: begin state_d = S_GETA; cls_d = C_CMP; end
          5'b101_10: begin state_d = S_GETA; cls_d = C_AND; end
          5'b101_11: begin state_d = S_GETB; cls_d = C_MVN; end
          default:   state_d = S_ILL;
        endcase
      end
      S_WIMM:   state_d = S_WAIT;
      S_GETA:   state_d = S_GETB;
      S_GETB:   state_d = (cls_q == C_CMP) ? S_CMP : S_ALU;
      S_ALU:    state_d = S_WREG;
      S_WREG:   state_d = S_WAIT;
      S_CMP:    state_d = S_WAIT;
      S_ILL:    state_d = S_WAIT;
      default:  state_d = S_WAIT;
    endcase
  end

  always_comb begin
    w_d       = 1'b0;
    nsel_d    = 3'b000;
    loada_d   = 1'b0;
    loadb_d   = 1'b0;
    loadc_d   = 1'b0;
    loads_d   = 1'b0;
    write_d   = 1'b0;
    vsel_d    = 2'b00;
    asel_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_d)
      S_WAIT: w_d = 1'b1;
      S_WIMM: begin nsel_d = 3'b001; vsel_d = 2'b10; write_d = 1'b1; end
      S_GETA: begin nsel_d = 3'b001; loada_d = 1'b1; end
      S_GETB: begin nsel_d = 3'b100; loadb_d = 1'b1; end
      // mov_q is already settled here: DECODE precedes ALU by at least one cycle.
      S_ALU:  begin loadc_d = 1'b1; asel_d = mov_q; end
      S_CMP:  loads_d = 1'b1;
      S_WREG: begin nsel_d = 3'b010; write_d = 1'b1; end
      S_ILL:  illegal_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_WAIT;
      cls_q     <= C_ADD;
      mov_q     <= 1'b0;
      w_q       <= 1'b1;
      nsel_q    <= 3'b000;
      loada_q   <= 1'b0;
      loadb_q   <= 1'b0;
      loadc_q   <= 1'b0;
      loads_q   <= 1'b0;
      write_q   <= 1'b0;
      vsel_q    <= 2'b00;
      asel_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      mov_q     <= mov_d;
      w_q       <= w_d;
      nsel_q    <= nsel_d;
      loada_q   <= loada_d;
      loadb_q   <= loadb_d;
      loadc_q   <= loadc_d;
      loads_q   <= loads_d;
      write_q   <= write_d;
      vsel_q    <= vsel_d;
      asel_q    <= asel_d;
      illegal_q <= illegal_d;
    end
  end

  assign w       = w_q;
  assign nsel    = nsel_q;
  assign loada   = loada_q;
  assign loadb   = loadb_q;
  assign loadc   = loadc_q;
  assign loads   = loads_q;
  assign write   = write_q;
  assign vsel    = vsel_q;
  assign asel    = asel_q;
  assign bsel    = 1'b0;
  assign illegal = illegal_q;

endmodule
